iq_inorder_sched: RTL and testbench
===================================

Name: iq_inorder_sched

Overview:
- Controls one in-order issue queue of QUEUE_SIZE entries in the backend issue stage (isu).
- Owns the per-entry valid bits, two operand-ready bits per entry, and the circular one-hot enqueue and dequeue pointers.
- Produces one-hot write enables for the external payload RAM and a head select for the read mux.
- Tracks writeback wakeups and issues the head entry to one functional unit through a valid/ready handshake.

Parameters:
QUEUE_SIZE, 8, number of entries; power of two, at least 2
PREG_W, 6, physical register tag width
CNT_W, $clog2(QUEUE_SIZE+1), occupancy counter width (derived)

Ports:
clock  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  synchronous pipeline flush; kills all entries
enq_valid  in  1  dispatch offers an instruction
enq_ready  out  1  queue can accept an entry; equals ~full
enq_src1_tag  in  PREG_W  source 1 physical tag
enq_src1_rdy  in  1  source 1 already available at dispatch
enq_src2_tag  in  PREG_W  source 2 physical tag
enq_src2_rdy  in  1  source 2 already available at dispatch
enq_wen_oh  out  QUEUE_SIZE  payload write enable; equals enq_ptr_oh when enqueue fires, else 0
wb_valid  in  1  writeback wakeup valid
wb_tag  in  PREG_W  writeback destination tag
deq_valid  out  1  head entry is valid and both sources are ready
deq_ready  in  1  functional unit accepts
deq_ptr_oh  out  QUEUE_SIZE  head entry one-hot; drives the payload read mux
enq_ptr_oh  out  QUEUE_SIZE  next allocation slot, one-hot
count  out  CNT_W  occupancy
empty  out  1  count == 0
full  out  1  count == QUEUE_SIZE

Behaviour:
- Reset (async) and flush (sync) leave the same state:
  - all valid and ready bits 0
  - enq_ptr_oh = deq_ptr_oh = 1 (bit 0 set)
  - count = 0, empty = 1, full = 0, deq_valid = 0, enq_ready = 1
- Flush priority: flush overrides any same-cycle enqueue, dequeue or wakeup. enq_wen_oh is 0 during flush.
- Enqueue: enq_fire = enq_valid & enq_ready & ~flush.
  - On fire, the entry at enq_ptr_oh gets valid = 1.
  - Each src ready bit = enq_srcN_rdy | (wb_valid & wb_tag == enq_srcN_tag). This is a same-cycle wakeup bypass.
  - enq_ptr_oh rotates left by 1, wrapping from MSB to bit 0.
- Wakeup: every valid entry whose stored tag equals wb_tag while wb_valid is high sets that source's ready bit the next cycle. Tags are stored in this block.
- Dequeue:
  - deq_valid = valid[head] & src1_rdy[head] & src2_rdy[head], taken from registered state only. It must not combinationally depend on the same-cycle wb_valid.
  - deq_fire = deq_valid & deq_ready & ~flush. On fire, valid[head] clears and deq_ptr_oh rotates left by 1 with wrap.
- Latency:
  - Enqueue to earliest issue: 1 cycle. An entry written in cycle N can present deq_valid in N+1.
  - A wakeup in cycle N makes deq_valid visible in N+1.
- Count:
  - count += enq_fire - deq_fire.
  - Simultaneous enqueue and dequeue leaves count unchanged and advances both pointers.
- Full: enq_ready = 0 at full. A dequeue while full does not permit a same-cycle enqueue; enq_ready rises the next cycle.
- Empty: deq_valid = 0 when empty. A same-cycle enqueue does not bypass to deq_valid.
- Ordering: strictly in order. A ready non-head entry never issues ahead of a non-ready head.
- Pointer invariant: deq_ptr_oh == enq_ptr_oh exactly when the queue is empty or full; count distinguishes the two.
- Assertions:
  - both pointers are always one-hot
  - enq_valid & ~enq_ready is allowed (dispatch holds the request)
  - count never exceeds QUEUE_SIZE

Decomposition:
- Shared isu package holds:
  - typedef iq_src_t {tag[PREG_W], rdy}
  - typedef iq_entry_state_t {valid, src1, src2}
  - localparam IQ_PTR_RESET = one-hot bit 0
- One sub-module, iq_src_wakeup: a per-entry tag compare and ready-bit register. It is instantiated QUEUE_SIZE×2 with enq-write, wb-compare and flush-clear inputs.
- The one-hot rotate is a small function in the package.

Test Plan:
1. Reset then enqueue 3 entries, all ready, with deq_ready=1 -> issues in cycles 2, 3, 4 with deq_ptr_oh 0x01, 0x02, 0x04; count returns to 0; empty=1.
2. Fill 8 entries with deq_ready=0 -> full=1, enq_ready=0, enq_ptr_oh=0x01, count=8. Then one dequeue -> enq_ready=1 the next cycle and the next enqueue writes enq_wen_oh=0x01 (wrap).
3. Head src1 tag 5 not ready, entry 1 ready -> deq_valid=0. Then wb_valid with wb_tag=5 in cycle N -> deq_valid=1 in N+1 with head 0x01; entry 1 issues after it.
4. Enqueue with src1_tag=9, src1_rdy=0 while wb_valid=1 and wb_tag=9 in the same cycle -> entry is issuable the next cycle.
5. Queue holds 5 entries; assert flush together with enq_fire and deq_ready -> next cycle count=0, both pointers 0x01, no entry written, nothing issued.
6. Assert reset asynchronously mid-stream with count=4 -> outputs take their reset values immediately; the first enqueue after release writes 0x01.

Source files
------------

// File: rtl/iq_inorder_sched_pkg.sv
// Shared isu issue-queue types, sizing and one-hot pointer helper.
// Queue sizing lives here so entry state, tags and pointer width agree everywhere.
package iq_inorder_sched_pkg;

  localparam int IQ_QUEUE_SIZE = 8;
  localparam int IQ_PREG_W     = 6;

  typedef logic [IQ_QUEUE_SIZE-1:0] iq_oh_t;

  typedef struct packed {
    logic [IQ_PREG_W-1:0] tag;
    logic                 rdy;
  } iq_src_t;

  typedef struct packed {
    logic valid;
    logic src1;
    logic src2;
  } iq_entry_state_t;

  localparam iq_oh_t IQ_PTR_RESET = iq_oh_t'(1);

  // Circular one-hot advance: MSB wraps back to bit 0.
  function automatic iq_oh_t iq_rotl_oh(input iq_oh_t oh);
    return {oh[IQ_QUEUE_SIZE-2:0], oh[IQ_QUEUE_SIZE-1]};
  endfunction

endpackage

// File: rtl/iq_src_wakeup.sv
// One source operand of one queue entry: stored tag plus ready bit,
// set at allocation (with same-cycle writeback bypass) or by a later wakeup.
module iq_src_wakeup
  import iq_inorder_sched_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 enq_we,
  input  logic [IQ_PREG_W-1:0] enq_tag,
  input  logic                 enq_rdy,
  input  logic                 entry_valid,
  input  logic                 wb_valid,
  input  logic [IQ_PREG_W-1:0] wb_tag,
  output logic                 rdy
);

  iq_src_t src_q;
  iq_src_t src_d;

  always_comb begin
    src_d = src_q;
    if (flush) begin
      src_d.rdy = 1'b0;
    end else if (enq_we) begin
      src_d.tag = enq_tag;
      src_d.rdy = enq_rdy | (wb_valid & (wb_tag == enq_tag));
    end else if (entry_valid & wb_valid & (wb_tag == src_q.tag)) begin
      src_d.rdy = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      src_q <= '0;
    end else begin
      src_q <= src_d;
    end
  end

  assign rdy = src_q.rdy;

endmodule

// File: rtl/iq_inorder_sched.sv
// In-order issue queue scheduler: valid/ready tracking, one-hot enq/deq
// pointers and head issue to a single functional unit.
module iq_inorder_sched
  import iq_inorder_sched_pkg::*;
#(
  parameter int QUEUE_SIZE = IQ_QUEUE_SIZE,
  parameter int PREG_W     = IQ_PREG_W,
  parameter int CNT_W      = $clog2(QUEUE_SIZE + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [PREG_W-1:0]     enq_src1_tag,
  input  logic                  enq_src1_rdy,
  input  logic [PREG_W-1:0]     enq_src2_tag,
  input  logic                  enq_src2_rdy,
  output logic [QUEUE_SIZE-1:0] enq_wen_oh,
  input  logic                  wb_valid,
  input  logic [PREG_W-1:0]     wb_tag,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [QUEUE_SIZE-1:0] deq_ptr_oh,
  output logic [QUEUE_SIZE-1:0] enq_ptr_oh,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  iq_oh_t           valid_q;
  iq_oh_t           valid_d;
  iq_oh_t           enq_ptr_q;
  iq_oh_t           enq_ptr_d;
  iq_oh_t           deq_ptr_q;
  iq_oh_t           deq_ptr_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  iq_oh_t          src1_rdy;
  iq_oh_t          src2_rdy;
  iq_oh_t          issuable;
  iq_entry_state_t entry_state [QUEUE_SIZE];

  logic enq_fire;
  logic deq_fire;

  assign full      = (count_q == CNT_W'(QUEUE_SIZE));
  assign empty     = (count_q == '0);
  assign enq_ready = ~full;
  assign count     = count_q;

  // Head issue looks only at registered state, so a wakeup never bypasses into deq_valid.
  assign deq_valid = |(deq_ptr_q & issuable);

  assign enq_fire   = enq_valid & enq_ready & ~flush;
  assign deq_fire   = deq_valid & deq_ready & ~flush;
  assign enq_wen_oh = enq_fire ? enq_ptr_q : '0;
  assign enq_ptr_oh = enq_ptr_q;
  assign deq_ptr_oh = deq_ptr_q;

  for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_entry
    iq_src_wakeup u_src1 (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .enq_we      (enq_wen_oh[i]),
      .enq_tag     (enq_src1_tag),
      .enq_rdy     (enq_src1_rdy),
      .entry_valid (valid_q[i]),
      .wb_valid    (wb_valid),
      .wb_tag      (wb_tag),
      .rdy         (src1_rdy[i])
    );

    iq_src_wakeup u_src2 (
      .clock       (clock),
      .reset       (reset),
      .flush       (flush),
      .enq_we      (enq_wen_oh[i]),
      .enq_tag     (enq_src2_tag),
      .enq_rdy     (enq_src2_rdy),
      .entry_valid (valid_q[i]),
      .wb_valid    (wb_valid),
      .wb_tag      (wb_tag),
      .rdy         (src2_rdy[i])
    );

    assign entry_state[i] = '{valid: valid_q[i], src1: src1_rdy[i], src2: src2_rdy[i]};
    assign issuable[i]    = entry_state[i].valid & entry_state[i].src1 & entry_state[i].src2;
  end

  // Enqueue and dequeue slots coincide only when empty or full, where one side cannot fire.
  always_comb begin
    valid_d   = valid_q;
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (flush) begin
      valid_d   = '0;
      enq_ptr_d = IQ_PTR_RESET;
      deq_ptr_d = IQ_PTR_RESET;
      count_d   = '0;
    end else begin
      if (deq_fire) begin
        valid_d   = valid_d & ~deq_ptr_q;
        deq_ptr_d = iq_rotl_oh(deq_ptr_q);
      end
      if (enq_fire) begin
        valid_d   = valid_d | enq_ptr_q;
        enq_ptr_d = iq_rotl_oh(enq_ptr_q);
      end
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q   <= '0;
      enq_ptr_q <= IQ_PTR_RESET;
      deq_ptr_q <= IQ_PTR_RESET;
      count_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

`ifndef SYNTHESIS
  a_enq_ptr_onehot : assert property (@(posedge clock) disable iff (reset) $onehot(enq_ptr_q));
  a_deq_ptr_onehot : assert property (@(posedge clock) disable iff (reset) $onehot(deq_ptr_q));
  a_count_bound    : assert property (@(posedge clock) disable iff (reset)
                                      count_q <= CNT_W'(QUEUE_SIZE));
  a_ptr_invariant  : assert property (@(posedge clock) disable iff (reset)
                                      (enq_ptr_q == deq_ptr_q) == (empty | full));
`endif

endmodule

// File: tb/tb_iq_inorder_sched.sv
// Randomized bench for iq_inorder_sched against an in-order queue model.
module tb_iq_inorder_sched;

  localparam int QS = 8;
  localparam int PW = 6;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [PW-1:0] enq_src1_tag;
  logic          enq_src1_rdy;
  logic [PW-1:0] enq_src2_tag;
  logic          enq_src2_rdy;
  logic [QS-1:0] enq_wen_oh;
  logic          wb_valid;
  logic [PW-1:0] wb_tag;
  logic          deq_valid;
  logic          deq_ready;
  logic [QS-1:0] deq_ptr_oh;
  logic [QS-1:0] enq_ptr_oh;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  always #5 clock = ~clock;

  iq_inorder_sched dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_src1_tag (enq_src1_tag),
    .enq_src1_rdy (enq_src1_rdy),
    .enq_src2_tag (enq_src2_tag),
    .enq_src2_rdy (enq_src2_rdy),
    .enq_wen_oh   (enq_wen_oh),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .deq_valid    (deq_valid),
    .deq_ready    (deq_ready),
    .deq_ptr_oh   (deq_ptr_oh),
    .enq_ptr_oh   (enq_ptr_oh),
    .count        (count),
    .empty        (empty),
    .full         (full)
  );

  typedef struct {
    logic [PW-1:0] tag1;
    bit            rdy1;
    logic [PW-1:0] tag2;
    bit            rdy2;
  } model_entry_t;

  model_entry_t model_q[$];
  int head_idx;
  int tail_idx;
  int tests;
  int fails;
  int cycle;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cycle, got, exp);
    end
  endtask

  function automatic bit modelHeadReady();
    if (model_q.size() == 0) return 1'b0;
    return model_q[0].rdy1 && model_q[0].rdy2;
  endfunction

  task automatic checkAll();
    bit exp_ready;
    bit exp_efire;
    exp_ready = (model_q.size() < QS);
    exp_efire = enq_valid && exp_ready && !flush;
    checkOutput("deq_valid", 32'(deq_valid), 32'(modelHeadReady()));
    checkOutput("deq_ptr",   32'(deq_ptr_oh), 32'(1) << head_idx);
    checkOutput("enq_ptr",   32'(enq_ptr_oh), 32'(1) << tail_idx);
    checkOutput("count",     32'(count), 32'(model_q.size()));
    checkOutput("empty",     32'(empty), 32'(model_q.size() == 0));
    checkOutput("full",      32'(full), 32'(model_q.size() == QS));
    checkOutput("enq_ready", 32'(enq_ready), 32'(exp_ready));
    checkOutput("enq_wen",   32'(enq_wen_oh), exp_efire ? (32'(1) << tail_idx) : 32'(0));
  endtask

  task automatic clearModel();
    model_q.delete();
    head_idx = 0;
    tail_idx = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic stepModel();
    bit dfire;
    bit efire;
    model_entry_t e;
    if (flush) begin
      clearModel();
      return;
    end
    dfire = modelHeadReady() && deq_ready;
    efire = enq_valid && (model_q.size() < QS);
    if (wb_valid) begin
      foreach (model_q[i]) begin
        if (model_q[i].tag1 == wb_tag) model_q[i].rdy1 = 1'b1;
        if (model_q[i].tag2 == wb_tag) model_q[i].rdy2 = 1'b1;
      end
    end
    if (dfire) begin
      void'(model_q.pop_front());
      head_idx = (head_idx + 1) % QS;
    end
    if (efire) begin
      e.tag1 = enq_src1_tag;
      e.rdy1 = enq_src1_rdy || (wb_valid && (wb_tag == enq_src1_tag));
      e.tag2 = enq_src2_tag;
      e.rdy2 = enq_src2_rdy || (wb_valid && (wb_tag == enq_src2_tag));
      model_q.push_back(e);
      tail_idx = (tail_idx + 1) % QS;
    end
  endtask

  task automatic applyStimulus(input int enq_pct, input int deq_pct, input int flush_pct);
    enq_valid    = ($urandom_range(99) < enq_pct);
    deq_ready    = ($urandom_range(99) < deq_pct);
    flush        = ($urandom_range(99) < flush_pct);
    enq_src1_tag = PW'($urandom_range(7));
    enq_src2_tag = PW'($urandom_range(7));
    enq_src1_rdy = ($urandom_range(99) < 40);
    enq_src2_rdy = ($urandom_range(99) < 40);
    wb_valid     = ($urandom_range(99) < 40);
    wb_tag       = PW'($urandom_range(7));
  endtask

  initial begin
    int phase;
    tests = 0;
    fails = 0;
    cycle = 0;
    reset = 1'b1;
    applyStimulus(0, 0, 0);
    flush = 1'b0;
    clearModel();
    repeat (2) @(negedge clock);
    #1;
    checkAll();
    reset = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      cycle = c;
      if (c % 700 == 350) begin
        // Mid-stream async reset: outputs must drop before any clock edge.
        applyStimulus(0, 0, 0);
        flush = 1'b0;
        reset = 1'b1;
        #1;
        clearModel();
        checkAll();
        @(negedge clock);
        reset = 1'b0;
        continue;
      end
      phase = (c / 200) % 4;
      case (phase)
        0:       applyStimulus(90, 10, 1);
        1:       applyStimulus(60, 70, 2);
        2:       applyStimulus(20, 95, 1);
        default: applyStimulus(70, 50, 4);
      endcase
      #1;
      checkAll();
      stepModel();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
